mmio_console_arbiter: RTL and testbench

- Shares the single MMIO address/write-data port between the CPU data port and an internal console fill engine.
- The engine clears the VGA text buffer, or fills one row of it, with a given character and colour.
- Sits between the pipeline's memory stage and the MMIO block.
- MMIO has no write enable and decodes writes purely from the address, so this block drives a neutral address whenever nobody owns the port.

---
 rtl/mmio_pkg.sv | 23 ++
 rtl/console_fill_fsm.sv | 129 ++++++++++++
 rtl/mmio_console_arbiter.sv | 95 +++++++++
 tb/tb_mmio_console_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared MMIO console constants, command opcodes and fill FSM states.
package mmio_pkg;

  localparam logic [31:0] CHAR_BASE  = 32'hFFFF_E000;
  localparam logic [31:0] COLOR_BASE = 32'hFFFF_D000;
  localparam logic [31:0] IDLE_ADDR  = 32'h0000_0000;

  // Text cell index width; the buffer holds at most 4096 cells.
  localparam int CELL_W = 12;

  typedef enum logic {
    CLEAR_ALL = 1'b0,
    FILL_ROW  = 1'b1
  } console_op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_CHAR  = 2'd1,
    WR_COLOR = 2'd2,
    FINISH   = 2'd3
  } fill_state_e;

endpackage

// File: rtl/console_fill_fsm.sv
// console_fill_fsm: latches a console command and walks the target cells,
// writing the character plane then the colour plane for each cell.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for a command, cmd_ready high
//   WR_CHAR  | write char of current cell (holds while stalled)
//   WR_COLOR | write colour of current cell, then next cell or FINISH
//   FINISH   | one-cycle done pulse (plus error pulse for a bad row)
module console_fill_fsm
  import mmio_pkg::*;
#(
  parameter int COLS = 64,
  parameter int ROWS = 48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_stall,
  input  logic        i_cmd_valid,
  input  logic        i_cmd_op,
  input  logic [5:0]  i_cmd_row,
  input  logic [7:0]  i_cmd_char,
  input  logic [7:0]  i_cmd_color,
  output logic        o_cmd_ready,
  output logic        o_active,
  output logic        o_finish,
  output logic        o_err,
  output logic [31:0] o_eng_addr,
  output logic [31:0] o_eng_wdata
);

  localparam logic [CELL_W-1:0] LAST_ALL = CELL_W'(COLS * ROWS - 1);
  localparam logic [CELL_W-1:0] COLS_C   = CELL_W'(COLS);
  localparam logic [CELL_W-1:0] COLS_M1  = CELL_W'(COLS - 1);

  fill_state_e       r_state;
  fill_state_e       w_next;
  logic [CELL_W-1:0] r_cell;
  logic [CELL_W-1:0] r_last;
  logic [7:0]        r_char;
  logic [7:0]        r_color;
  logic              r_bad;
  logic [CELL_W-1:0] w_row_base;
  logic              w_row_bad;
  logic              w_is_fill;
  logic              w_accept;
  logic              w_step;

  assign w_is_fill  = (console_op_e'(i_cmd_op) == FILL_ROW);
  assign w_row_base = CELL_W'(i_cmd_row) * COLS_C;
  assign w_row_bad  = w_is_fill && (int'(i_cmd_row) >= ROWS);

  // Next-state logic; the write states only move on cycles the port is ours.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_step   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_cmd_valid) begin
          w_accept = 1'b1;
          w_next   = w_row_bad ? FINISH : WR_CHAR;
        end
      end
      WR_CHAR: begin
        if (!i_stall) w_next = WR_COLOR;
      end
      WR_COLOR: begin
        if (!i_stall) begin
          if (r_cell == r_last) begin
            w_next = FINISH;
          end else begin
            w_next = WR_CHAR;
            w_step = 1'b1;
          end
        end
      end
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register plus command latch and cell counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cell  <= '0;
      r_last  <= '0;
      r_char  <= '0;
      r_color <= '0;
      r_bad   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_char  <= i_cmd_char;
        r_color <= i_cmd_color;
        r_bad   <= w_row_bad;
        if (w_is_fill) begin
          r_cell <= w_row_base;
          r_last <= w_row_base + COLS_M1;
        end else begin
          r_cell <= '0;
          r_last <= LAST_ALL;
        end
      end else if (w_step) begin
        r_cell <= r_cell + CELL_W'(1);
      end
    end
  end

  // Engine-side address/data for whichever plane the current state writes.
  always_comb begin
    o_eng_addr  = IDLE_ADDR;
    o_eng_wdata = '0;
    if (r_state == WR_CHAR) begin
      o_eng_addr  = CHAR_BASE | {20'h0, r_cell};
      o_eng_wdata = {24'h0, r_char};
    end else if (r_state == WR_COLOR) begin
      o_eng_addr  = COLOR_BASE | {20'h0, r_cell};
      o_eng_wdata = {24'h0, r_color};
    end
  end

  assign o_cmd_ready = (r_state == IDLE);
  assign o_active    = (r_state == WR_CHAR) || (r_state == WR_COLOR);
  assign o_finish    = (r_state == FINISH);
  assign o_err       = (r_state == FINISH) && r_bad;

endmodule

// File: rtl/mmio_console_arbiter.sv
// mmio_console_arbiter: shares the MMIO address/data port between the CPU
// data port and the console fill engine. The CPU normally has strict priority.
// Optional macro MMIO_FAIR_ARB_EN: after MAX_CPU_RUN consecutive CPU-owned
// cycles against an active engine, the engine gets one forced slot.
module mmio_console_arbiter
  import mmio_pkg::*;
#(
  parameter int COLS        = 64,
  parameter int ROWS        = 48,
  parameter int MAX_CPU_RUN = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_grant,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [5:0]  cmd_row,
  input  logic [7:0]  cmd_char,
  input  logic [7:0]  cmd_color,
  output logic [31:0] mmio_addr,
  output logic [31:0] mmio_wdata,
  output logic        busy,
  output logic        done,
  output logic        cmd_err
);

  logic        w_eng_ready;
  logic        w_eng_active;
  logic        w_eng_finish;
  logic        w_eng_err;
  logic [31:0] w_eng_addr;
  logic [31:0] w_eng_wdata;
  logic        w_force;

  console_fill_fsm #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) u_fill (
    .clk         (clk),
    .reset       (reset),
    .i_stall     (cpu_grant),
    .i_cmd_valid (cmd_valid),
    .i_cmd_op    (cmd_op),
    .i_cmd_row   (cmd_row),
    .i_cmd_char  (cmd_char),
    .i_cmd_color (cmd_color),
    .o_cmd_ready (w_eng_ready),
    .o_active    (w_eng_active),
    .o_finish    (w_eng_finish),
    .o_err       (w_eng_err),
    .o_eng_addr  (w_eng_addr),
    .o_eng_wdata (w_eng_wdata)
  );

`ifdef MMIO_FAIR_ARB_EN
  localparam int RUN_W = $clog2(MAX_CPU_RUN + 1);
  logic [RUN_W-1:0] r_run;

  assign w_force = w_eng_active && (r_run == RUN_W'(MAX_CPU_RUN));

  // Count consecutive CPU-owned cycles that are holding off an active engine.
  always_ff @(posedge clk) begin
    if (reset || !cpu_req || w_force || !w_eng_active) r_run <= '0;
    else                                               r_run <= r_run + RUN_W'(1);
  end
`else
  logic w_unused_max_run;
  assign w_unused_max_run = (MAX_CPU_RUN != 0);
  assign w_force          = 1'b0;
`endif

  assign cpu_grant = cpu_req && !reset && !w_force;
  assign cmd_ready = w_eng_ready && !reset;
  assign busy      = w_eng_active && !reset;
  assign done      = w_eng_finish && !reset;
  assign cmd_err   = w_eng_err && !reset;

  // Port mux; MMIO decodes purely on address, so an unowned port is parked.
  always_comb begin
    mmio_addr  = IDLE_ADDR;
    mmio_wdata = '0;
    if (cpu_grant) begin
      mmio_addr  = cpu_addr;
      mmio_wdata = cpu_wdata;
    end else if (busy) begin
      mmio_addr  = w_eng_addr;
      mmio_wdata = w_eng_wdata;
    end
  end

endmodule

// File: tb/tb_mmio_console_arbiter.sv
module tb_mmio_console_arbiter;

  localparam int COLS    = 64;
  localparam int ROWS    = 48;
  localparam int MAX_RUN = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_op = 1'b0;
  logic [5:0]  cmd_row = '0;
  logic [7:0]  cmd_char = '0;
  logic [7:0]  cmd_color = '0;
  logic        cpu_grant;
  logic        cmd_ready;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_wdata;
  logic        busy;
  logic        done;
  logic        cmd_err;

  mmio_console_arbiter #(.COLS(COLS), .ROWS(ROWS), .MAX_CPU_RUN(MAX_RUN)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_grant  (cpu_grant),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_row    (cmd_row),
    .cmd_char   (cmd_char),
    .cmd_color  (cmd_color),
    .mmio_addr  (mmio_addr),
    .mmio_wdata (mmio_wdata),
    .busy       (busy),
    .done       (done),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Behavioural model: a command expands into the list of MMIO writes it must
  // produce; the engine drains one entry per cycle the CPU does not own the port.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t q[$];
  bit  fin     = 1'b0;
  bit  fin_err = 1'b0;
  int  m_run   = 0;

  function automatic void load_cmd(bit op, int row, logic [7:0] ch, logic [7:0] co);
    int  first;
    int  n;
    wr_t w;
    if (op && row >= ROWS) begin
      fin     = 1'b1;
      fin_err = 1'b1;
      return;
    end
    first = op ? row * COLS : 0;
    n     = op ? COLS : COLS * ROWS;
    for (int c = first; c < first + n; c++) begin
      w.a = 32'hFFFF_E000 + 32'(c);
      w.d = {24'h0, ch};
      q.push_back(w);
      w.a = 32'hFFFF_D000 + 32'(c);
      w.d = {24'h0, co};
      q.push_back(w);
    end
  endfunction

  always @(negedge clk) begin : cmp
    bit          eng;
    bit          fslot;
    bit          eg;
    bit          edone;
    bit          eready;
    logic [31:0] ea;
    logic [31:0] ed;
    eng   = !reset && (q.size() != 0);
    fslot = 1'b0;
`ifdef MMIO_FAIR_ARB_EN
    fslot = eng && (m_run == MAX_RUN);
`endif
    eg     = cpu_req && !reset && !fslot;
    edone  = !reset && (q.size() == 0) && fin;
    eready = !reset && (q.size() == 0) && !fin;
    ea = 32'h0;
    ed = 32'h0;
    if (eg) begin
      ea = cpu_addr;
      ed = cpu_wdata;
    end else if (eng) begin
      ea = q[0].a;
      ed = q[0].d;
    end
    chk("grant", cpu_grant, eg);
    chk("busy", busy, eng);
    chk("ready", cmd_ready, eready);
    chk("done", done, edone);
    chk("cmd_err", cmd_err, edone && fin_err);
    chk("mmio_addr", mmio_addr, ea);
    chk("mmio_wdata", mmio_wdata, ed);
    if (reset) begin
      q.delete();
      fin     = 1'b0;
      fin_err = 1'b0;
      m_run   = 0;
    end else begin
      if (!cpu_req || fslot || !eng) m_run = 0;
      else                           m_run++;
      if (eng && !eg) begin
        void'(q.pop_front());
        if (q.size() == 0) begin
          fin     = 1'b1;
          fin_err = 1'b0;
        end
      end else if (edone) begin
        fin     = 1'b0;
        fin_err = 1'b0;
      end else if (eready && cmd_valid) begin
        load_cmd(cmd_op, int'(cmd_row), cmd_char, cmd_color);
      end
    end
  end

  int acc = 0;

  task automatic issue(bit op, logic [5:0] row, logic [7:0] ch, logic [7:0] co, bit hold);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_row   = row;
    cmd_char  = ch;
    cmd_color = co;
    @(negedge clk);
    chk("accept_ready", cmd_ready, 1);
    acc = cyc;
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic at_rel(int k);
    do @(negedge clk); while (cyc < acc + k);
  endtask

  task automatic drive_at(int k);
    while (cyc < acc + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(int max, output int rel);
    rel = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        rel = cyc - acc;
        break;
      end
    end
    if (rel < 0) begin
      n_checks++;
      n_err++;
      $display("FAIL done_timeout: no done within %0d cycles", max);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    int nd;

    // Reset behaviour
    @(negedge clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_grant", cpu_grant, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_addr", mmio_addr, 32'h0);

    // FILL_ROW row 2, no CPU traffic
    issue(1'b1, 6'd2, 8'h41, 8'h1F, 1'b0);
    at_rel(1);
    chk("t1_first_addr", mmio_addr, 32'hFFFF_E080);
    chk("t1_first_data", mmio_wdata, 32'h41);
    at_rel(2);
    chk("t1_second_addr", mmio_addr, 32'hFFFF_D080);
    chk("t1_second_data", mmio_wdata, 32'h1F);
    at_rel(128);
    chk("t1_last_addr", mmio_addr, 32'hFFFF_D0BF);
    wait_done(300, d);
    chk("t1_done_lat", d, 129);
    at_rel(130);
    chk("t1_idle_addr", mmio_addr, 32'h0);

    // CLEAR_ALL with CPU traffic in cycles 10..19
    issue(1'b0, 6'd0, 8'h20, 8'h07, 1'b0);
    at_rel(9);
    chk("t2_pre_stall_addr", mmio_addr, 32'hFFFF_E004);
    drive_at(10);
    cpu_req   = 1'b1;
    cpu_addr  = 32'h0000_4000;
    cpu_wdata = 32'hDEAD_BEEF;
    at_rel(15);
    chk("t2_cpu_grant", cpu_grant, 1);
    chk("t2_cpu_addr", mmio_addr, 32'h0000_4000);
    chk("t2_cpu_data", mmio_wdata, 32'hDEAD_BEEF);
    drive_at(20);
    cpu_req = 1'b0;
    at_rel(20);
    chk("t2_resume_addr", mmio_addr, 32'hFFFF_D004);
    chk("t2_resume_data", mmio_wdata, 32'h07);
    wait_done(6400, d);
    chk("t2_done_lat", d, 6155);

    // FILL_ROW with an out-of-range row
    issue(1'b1, 6'd48, 8'h11, 8'h22, 1'b0);
    at_rel(1);
    chk("t3_done", done, 1);
    chk("t3_err", cmd_err, 1);
    chk("t3_addr", mmio_addr, 32'h0);
    at_rel(2);
    chk("t3_ready_again", cmd_ready, 1);

    // Reset in the middle of a CLEAR_ALL
    issue(1'b0, 6'd0, 8'h33, 8'h4E, 1'b0);
    drive_at(50);
    reset = 1'b1;
    drive_at(51);
    reset = 1'b0;
    at_rel(51);
    chk("t4_ready", cmd_ready, 1);
    chk("t4_addr", mmio_addr, 32'h0);
    chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);
    nd = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    chk("t4_no_done", nd, 0);

    // cmd_valid held through a busy command
    issue(1'b1, 6'd5, 8'h55, 8'h0A, 1'b1);
    cmd_row   = 6'd7;
    cmd_char  = 8'h66;
    cmd_color = 8'h0C;
    wait_done(300, d);
    chk("t5_first_done", d, 129);
    at_rel(130);
    chk("t5_second_accept", cmd_ready, 1);
    drive_at(131);
    cmd_valid = 1'b0;
    at_rel(131);
    chk("t5_second_addr", mmio_addr, 32'hFFFF_E1C0);
    chk("t5_second_data", mmio_wdata, 32'h66);
    acc = acc + 130;
    wait_done(300, d);
    chk("t5_second_done", d, 129);

`ifdef MMIO_FAIR_ARB_EN
    // Fair arbitration against a CPU that never lets go
    cpu_req   = 1'b1;
    cpu_addr  = 32'h0000_1234;
    cpu_wdata = 32'h0000_5678;
    issue(1'b1, 6'd3, 8'h2A, 8'h5E, 1'b0);
    for (int r = 1; r <= 51; r++) begin
      at_rel(r);
      chk("t6_grant_pattern", cpu_grant, ((r % 17) != 0) ? 1 : 0);
    end
    wait_done(2400, d);
    chk("t6_done_lat", d, 2177);
    cpu_req = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
